// File: rtl/neuron_update_sched_pkg.sv
// rtl/neuron_update_sched_pkg.sv - shared types and defaults for the neuron update scheduler
package neuron_update_sched_pkg;

  localparam int N_NEUR_DEF = 256;
  localparam int AW_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LEAK = 2'd0,
    EXC  = 2'd1,
    INH  = 2'd2
  } op_t;

endpackage

// File: rtl/neuron_update_arbiter.sv
// rtl/neuron_update_arbiter.sv - alternating syn/leak arbiter with the pending-tick flag
module neuron_update_arbiter
  import neuron_update_sched_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic sweep_end,
  input  logic decide,
  input  logic syn_req,
  output logic grant_syn,
  output logic grant_leak,
  output logic miss
);

  logic active_q;
  logic pend_q;
  logic last_syn_q;
  logic leak_req;

  // The final neuron of a sweep is already in flight during its WRITE, so it no longer requests.
  assign leak_req   = active_q & ~sweep_end;
  assign grant_syn  = decide & syn_req & (~leak_req | ~last_syn_q);
  assign grant_leak = decide & leak_req & (~syn_req | last_syn_q);
  assign miss       = tick & active_q & pend_q & ~sweep_end;

  always_ff @(posedge CLK) begin
    if (RST) begin
      active_q   <= 1'b0;
      pend_q     <= 1'b0;
      last_syn_q <= 1'b0;
    end else begin
      if (grant_syn) begin
        last_syn_q <= 1'b1;
      end else if (grant_leak) begin
        last_syn_q <= 1'b0;
      end

      if (sweep_end) begin
        active_q <= pend_q;
        pend_q   <= tick;
      end else if (active_q) begin
        if (tick) begin
          pend_q <= 1'b1;
        end
      end else if (pend_q | tick) begin
        active_q <= 1'b1;
        pend_q   <= pend_q & tick;
      end
    end
  end

endmodule

// File: rtl/neuron_update_sched.sv
// rtl/neuron_update_sched.sv - READ/WRITE scheduler sharing one accumulator across neurons
// Leak sweep engine compiled in only with NEURON_UPDATE_SCHED_LEAK_EN.
module neuron_update_sched
  import neuron_update_sched_pkg::*;
#(
  parameter int N_NEUR = N_NEUR_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          leak_tick,
  input  logic          syn_req,
  input  logic [AW-1:0] syn_neur,
  input  logic [2:0]    syn_weight,
  input  logic          syn_inh,
  output logic          syn_ack,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic          event_leak,
  output logic          event_exc,
  output logic          event_inh,
  output logic [2:0]    weight_out,
  output logic          busy,
  output logic          sweep_done,
  output logic          leak_miss
);

  state_t        state_q, state_d;
  op_t           op_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    weight_q;
  logic [AW-1:0] leak_addr;
  logic          decide, grant_syn, grant_leak;
  logic          tick_in, sweep_end, arb_miss;

  assign decide = (state_q == IDLE) || (state_q == WRITE);

  neuron_update_arbiter u_arb (
    .CLK        (CLK),
    .RST        (RST),
    .tick       (tick_in),
    .sweep_end  (sweep_end),
    .decide     (decide),
    .syn_req    (syn_req),
    .grant_syn  (grant_syn),
    .grant_leak (grant_leak),
    .miss       (arb_miss)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WRITE: state_d = (grant_syn || grant_leak) ? READ : IDLE;
      READ:        state_d = WRITE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= LEAK;
      addr_q   <= '0;
      weight_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_syn) begin
        op_q     <= syn_inh ? INH : EXC;
        addr_q   <= syn_neur;
        weight_q <= syn_weight;
      end else if (grant_leak) begin
        op_q     <= LEAK;
        addr_q   <= leak_addr;
        weight_q <= '0;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign sram_cs    = busy;
  assign sram_we    = (state_q == WRITE);
  assign sram_addr  = busy ? addr_q : '0;
  assign syn_ack    = (state_q == READ) && (op_q != LEAK);
  assign event_exc  = (state_q == WRITE) && (op_q == EXC);
  assign event_inh  = (state_q == WRITE) && (op_q == INH);
  assign weight_out = (state_q == WRITE) ? weight_q : 3'd0;

`ifdef NEURON_UPDATE_SCHED_LEAK_EN
  localparam logic [AW-1:0] LAST = AW'(N_NEUR - 1);
  logic [AW-1:0] leak_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      leak_cnt <= '0;
    end else if (grant_leak) begin
      leak_cnt <= (leak_cnt == LAST) ? '0 : leak_cnt + AW'(1);
    end
  end

  assign tick_in    = leak_tick;
  assign leak_addr  = leak_cnt;
  assign sweep_end  = (state_q == WRITE) && (op_q == LEAK) && (addr_q == LAST);
  assign event_leak = (state_q == WRITE) && (op_q == LEAK);
  assign sweep_done = sweep_end;
  assign leak_miss  = arb_miss;
`else
  logic unused_leak;
  assign unused_leak = leak_tick | arb_miss;
  assign tick_in     = 1'b0;
  assign leak_addr   = '0;
  assign sweep_end   = 1'b0;
  assign event_leak  = 1'b0;
  assign sweep_done  = 1'b0;
  assign leak_miss   = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_update_sched.sv
// tb/tb_neuron_update_sched.sv - cycle-by-cycle bench: directed table, random syn timeline, leak scenarios
`timescale 1ns/1ps
module tb_neuron_update_sched;

  localparam int N  = 256;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST, leak_tick, syn_req, syn_inh;
  logic [AW-1:0] syn_neur;
  logic [2:0]    syn_weight;
  logic          syn_ack, sram_cs, sram_we, event_leak, event_exc, event_inh;
  logic          busy, sweep_done, leak_miss;
  logic [AW-1:0] sram_addr;
  logic [2:0]    weight_out;

  always #5 CLK = ~CLK;

  neuron_update_sched #(.N_NEUR(N), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .leak_tick(leak_tick), .syn_req(syn_req), .syn_neur(syn_neur),
    .syn_weight(syn_weight), .syn_inh(syn_inh), .syn_ack(syn_ack), .sram_cs(sram_cs),
    .sram_we(sram_we), .sram_addr(sram_addr), .event_leak(event_leak), .event_exc(event_exc),
    .event_inh(event_inh), .weight_out(weight_out), .busy(busy), .sweep_done(sweep_done),
    .leak_miss(leak_miss)
  );

  typedef struct packed {
    logic rst, tick, req;
    logic [7:0] neur;
    logic [2:0] w;
    logic inh;
  } in_t;

  typedef struct packed {
    logic busy, cs, we;
    logic [7:0] addr;
    logic ack, el, ee, ei;
    logic [2:0] w;
    logic sd, lm;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  in_t  stim[$];
  out_t expv[$];

  function automatic in_t mk_in(bit rst, bit req, int n, int w, bit inh);
    in_t v;
    v = '0; v.rst = rst; v.req = req; v.neur = 8'(n); v.w = 3'(w); v.inh = inh;
    return v;
  endfunction

  function automatic out_t rd_o(int a, bit ack);
    out_t r;
    r = '0; r.busy = 1'b1; r.cs = 1'b1; r.addr = 8'(a); r.ack = ack;
    return r;
  endfunction

  // kind: 0 leak, 1 excitatory, 2 inhibitory
  function automatic out_t wr_o(int a, int kind, int w);
    out_t r;
    r = '0; r.busy = 1'b1; r.cs = 1'b1; r.we = 1'b1; r.addr = 8'(a);
    r.el = (kind == 0); r.ee = (kind == 1); r.ei = (kind == 2); r.w = 3'(w);
    r.sd = (kind == 0) && (a == N - 1);
    return r;
  endfunction

  function automatic vec_t row(in_t i, out_t o);
    vec_t v;
    v.i = i; v.o = o;
    return v;
  endfunction

  task automatic alloc(input int n);
    stim.delete(); expv.delete();
    for (int k = 0; k < n; k++) begin
      stim.push_back('0); expv.push_back('0);
    end
  endtask

  task automatic put_op(input int c, input int kind, input int a, input int w);
    expv[c]     = rd_o(a, kind != 0);
    expv[c + 1] = wr_o(a, kind, kind == 0 ? 0 : w);
  endtask

  task automatic put_leaks(input int c, input int lo, input int hi, output int nxt);
    nxt = c;
    for (int a = lo; a <= hi; a++) begin
      put_op(nxt, 0, a, 0);
      nxt += 2;
    end
  endtask

  // request held from 'from' up to and including its READ cycle 'rd'
  task automatic put_syn(input int from, input int rd, input int a, input int w, input bit inh);
    in_t v;
    for (int k = from; k <= rd; k++) begin
      v = stim[k]; v.req = 1'b1; v.neur = 8'(a); v.w = 3'(w); v.inh = inh; stim[k] = v;
    end
    put_op(rd, inh ? 2 : 1, a, w);
  endtask

  task automatic set_tick(input int c);
    in_t v;
    v = stim[c]; v.tick = 1'b1; stim[c] = v;
  endtask

  task automatic set_rst(input int c);
    in_t v;
    v = stim[c]; v.rst = 1'b1; stim[c] = v;
  endtask

  task automatic drive(input in_t v);
    RST = v.rst; leak_tick = v.tick; syn_req = v.req;
    syn_neur = v.neur; syn_weight = v.w; syn_inh = v.inh;
  endtask

  task automatic check(input out_t want, input string nm, input int c);
    out_t got;
    got = {busy, sram_cs, sram_we, sram_addr, syn_ack, event_leak, event_exc, event_inh,
           weight_out, sweep_done, leak_miss};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got %05h required %05h", nm, c, got, want);
    end
  endtask

  task automatic run(input string nm);
    for (int c = 0; c < stim.size(); c++) begin
      drive(stim[c]);
      @(negedge CLK);
      check(expv[c], nm, c);
      @(posedge CLK);
      #1;
    end
  endtask

  vec_t tbl[14];
  int   c, r, nxt;

  initial begin
    drive(mk_in(1'b1, 1'b0, 0, 0, 1'b0));
    repeat (3) @(posedge CLK);
    #1;

    tbl[0]  = row(mk_in(1, 0, 0, 0, 0),     '0);
    tbl[1]  = row(mk_in(0, 1, 5, 3, 0),     '0);
    tbl[2]  = row(mk_in(0, 1, 5, 3, 0),     rd_o(5, 1));
    tbl[3]  = row(mk_in(0, 0, 0, 0, 0),     wr_o(5, 1, 3));
    tbl[4]  = row(mk_in(0, 0, 0, 0, 0),     '0);
    tbl[5]  = row(mk_in(0, 1, 200, 7, 1),   '0);
    tbl[6]  = row(mk_in(0, 1, 200, 7, 1),   rd_o(200, 1));
    tbl[7]  = row(mk_in(0, 1, 9, 1, 0),     wr_o(200, 2, 7));
    tbl[8]  = row(mk_in(0, 1, 9, 1, 0),     rd_o(9, 1));
    tbl[9]  = row(mk_in(0, 0, 0, 0, 0),     wr_o(9, 1, 1));
    tbl[10] = row(mk_in(0, 1, 33, 5, 1),    '0);
    tbl[11] = row(mk_in(1, 1, 33, 5, 1),    rd_o(33, 1));
    tbl[12] = row(mk_in(0, 0, 0, 0, 0),     '0);
    tbl[13] = row(mk_in(0, 0, 0, 0, 0),     '0);
    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].i);
      @(negedge CLK);
      check(tbl[k].o, "table", k);
      @(posedge CLK);
      #1;
    end

    // random syn traffic: a request presented in cycle r is read in r+1
    alloc(260);
    c = 2;
    for (int k = 0; k < 40; k++) begin
      r = c + int'($urandom_range(0, 3));
      put_syn(r, r + 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)));
      c = r + 2;
    end
    run("rand_syn");

`ifdef NEURON_UPDATE_SCHED_LEAK_EN
    // full sweep; a tick in the sweep_done cycle queues one more sweep with no miss
    alloc(1034);
    set_tick(1);
    put_leaks(3, 0, N - 1, nxt);
    set_tick(514);
    put_leaks(517, 0, N - 1, nxt);
    run("sweep");

    // syn inserted after neuron 10, then strict alternation with a second held event
    alloc(524);
    set_tick(1);
    put_leaks(3, 0, 10, nxt);
    put_syn(24, 25, 77, 6, 1'b0);
    put_op(27, 0, 11, 0);
    put_syn(26, 29, 140, 2, 1'b1);
    put_leaks(31, 12, N - 1, nxt);
    run("insert");

    // three ticks in one sweep: second queues, third is dropped
    alloc(1034);
    set_tick(1); set_tick(11); set_tick(21);
    put_leaks(3, 0, N - 1, nxt);
    put_leaks(516, 0, N - 1, nxt);
    expv[21].lm = 1'b1;
    run("ticks3");

    // reset in the WRITE of neuron 7, then a fresh sweep starts at neuron 0
    alloc(45);
    set_tick(1);
    put_leaks(3, 0, 7, nxt);
    set_rst(18);
    set_tick(22);
    put_leaks(24, 0, 3, nxt);
    set_rst(31);
    run("rst_mid");
`else
    // leak engine absent: ticks ignored, syn served normally
    alloc(14);
    set_tick(1); set_tick(2); set_tick(5); set_tick(6);
    put_syn(6, 7, 12, 4, 1'b0);
    run("noleak");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neuron_update_sched.md
NEURON_UPDATE_SCHED -- requirements
Module: neuron_update_sched

Interface
REQ-001 SHALL have parameter N_NEUR, default 256, number of neurons sharing one input-accumulator datapath.
REQ-002 SHALL have parameter AW, default 8, neuron address width, with 2^AW >= N_NEUR.
REQ-003 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port leak_tick  in  1  single-cycle request for a leak sweep over all neurons.
REQ-006 SHALL have port syn_req  in  1  synaptic event request, held until acknowledged.
REQ-007 SHALL have port syn_neur  in  AW  target neuron of the synaptic event.
REQ-008 SHALL have port syn_weight  in  3  synaptic weight.
REQ-009 SHALL have port syn_inh  in  1  1 = inhibitory, 0 = excitatory.
REQ-010 SHALL have port syn_ack  out  1  one-cycle pulse, event accepted.
REQ-011 SHALL have ports sram_cs, sram_we (out, 1 each) and sram_addr (out, AW), the neuron-state SRAM controls.
REQ-012 SHALL have ports event_leak, event_exc, event_inh (out, 1 each) and weight_out (out, 3), the accumulator datapath controls.
REQ-013 SHALL have ports busy, sweep_done, leak_miss (out, 1 each): operation in progress; last sweep write done (pulse); tick dropped (pulse).

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE; each neuron update SHALL take exactly 2 cycles (READ then WRITE).
REQ-015 In READ, SHALL drive sram_cs=1, sram_we=0, sram_addr=target, with all event_* = 0.
REQ-016 In WRITE, SHALL drive sram_cs=1, sram_we=1, the same sram_addr, and exactly one event_* = 1 matching the operation type.
REQ-017 SHALL return from WRITE directly to READ when another operation is pending; otherwise to IDLE.
REQ-018 SHALL pulse syn_ack in the READ cycle of the accepted event, latching syn_neur, syn_weight and syn_inh on that edge.
REQ-019 SHALL drive weight_out from the latched weight during WRITE, and 0 otherwise.
REQ-020 On a leak sweep, SHALL update neurons 0..N_NEUR-1 in ascending order using an internal AW-bit counter.
REQ-021 SHALL pulse sweep_done in the WRITE cycle of neuron N_NEUR-1.
REQ-022 Arbitration: when both a leak update and syn_req are pending at an operation boundary, SHALL alternate strictly, starting with syn; a lone requester SHALL be served back-to-back.
REQ-023 SHALL hold one pending-tick flag; a tick arriving while sweeping SHALL set it, and the next sweep SHALL start after the current one ends.
REQ-024 A tick arriving while the flag is already set SHALL pulse leak_miss and be dropped.
REQ-025 A tick and the final sweep_done in the same cycle SHALL set the flag, with no leak_miss.
REQ-026 SHALL drive busy=1 in READ and WRITE, and busy=0 in IDLE.
REQ-027 Read-after-write on the same neuron SHALL require no stall, since each write completes before the next read.

Reset
REQ-028 On RST, SHALL enter IDLE, clear the sweep counter, pending flag and latches, and drive every output to 0 in the following cycle.
REQ-029 RST mid-operation SHALL abandon the operation with no SRAM write and no syn_ack issued afterwards.

Configuration
REQ-030 With macro NEURON_UPDATE_SCHED_LEAK_EN defined, the leak sweep engine (REQ-020..025) SHALL be compiled in.
REQ-031 Without NEURON_UPDATE_SCHED_LEAK_EN: leak_tick SHALL be ignored; event_leak, sweep_done and leak_miss SHALL be tied 0; syn events SHALL be served back-to-back.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, N_NEUR/AW defaults and the operation-type enumeration (LEAK, EXC, INH).
REQ-033 The block SHALL contain one sub-module, neuron_update_arbiter: the alternating two-requester arbiter with the pending-tick flag.

Verification
REQ-034 syn_req, syn_neur=5, syn_weight=3, syn_inh=0 from IDLE -> READ addr 5 with syn_ack, then WRITE addr 5 with event_exc=1, weight_out=3, then IDLE.
REQ-035 leak_tick, N_NEUR=256, no syn traffic -> 512 busy cycles, addresses 0..255, sweep_done in cycle 512.
REQ-036 syn_req held during a sweep after neuron 10 -> syn update inserted after leak neuron 10, and leak resumes at neuron 11.
REQ-037 Three ticks during one sweep -> 2nd tick sets the flag, 3rd tick pulses leak_miss; exactly one extra sweep follows.
REQ-038 RST in the WRITE cycle of neuron 7 -> no write to 7 the next cycle, all outputs 0, and a new tick restarts at neuron 0.
REQ-039 Build without NEURON_UPDATE_SCHED_LEAK_EN, leak_tick pulsed -> busy stays 0 and event_leak is never asserted.
